// File: rtl/regfile_pkg.sv
// Shared types and sizes for the integer register file write-back path.
package regfile_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef enum logic {
        GNT_LD  = 1'b0,
        GNT_ALU = 1'b1
    } grant_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; req[0]/gnt[0] is the load unit, req[1]/gnt[1] the ALU.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clock,
    input  logic       nreset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    grant_t last_grant;
    grant_t last_grant_next;

    // Reset to ALU so the load unit wins the first contention.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            last_grant <= GNT_ALU;
        end else begin
            last_grant <= last_grant_next;
        end
    end

    // Priority only rotates on cycles where both requesters compete.
    always_comb begin
        gnt             = 2'b00;
        last_grant_next = last_grant;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                if (last_grant == GNT_ALU) begin
                    gnt             = 2'b01;
                    last_grant_next = GNT_LD;
                end else begin
                    gnt             = 2'b10;
                    last_grant_next = GNT_ALU;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates load/ALU results onto the single register file
// write port and tracks pending destinations so decode can stall on RAW/WAW hazards.
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned n = 32
) (
    input  logic          clock,
    input  logic          nreset,
    input  logic          issue_en,
    input  reg_addr_t     issue_rd,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  reg_addr_t     ld_addr,
    input  logic [n-1:0]  ld_data,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  reg_addr_t     alu_addr,
    input  logic [n-1:0]  alu_data,
    output logic          regw,
    output reg_addr_t     waddr,
    output logic [n-1:0]  wdata,
    input  reg_addr_t     chk_r1,
    input  reg_addr_t     chk_r2,
    input  reg_addr_t     chk_rd,
    input  logic          chk_rd_en,
    output logic          stall
);

    logic [1:0]       gnt;
    logic             ld_xfer;
    logic             alu_xfer;
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;

    rr_arb2 u_arb (
        .clock  (clock),
        .nreset (nreset),
        .req    ({alu_valid, ld_valid}),
        .gnt    (gnt)
    );

    assign ld_ready  = gnt[0];
    assign alu_ready = gnt[1];
    assign ld_xfer   = ld_valid && ld_ready;
    assign alu_xfer  = alu_valid && alu_ready;

    // Output stage drains every cycle; writes to x0 are accepted but never enable regw.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            regw  <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            regw <= 1'b0;
            if (ld_xfer) begin
                waddr <= ld_addr;
                wdata <= ld_data;
                regw  <= (ld_addr != '0);
            end else if (alu_xfer) begin
                waddr <= alu_addr;
                wdata <= alu_data;
                regw  <= (alu_addr != '0);
            end
        end
    end

    // Clear on commit first so a same-cycle issue to the same register wins.
    always_comb begin
        busy_next = busy;
        if (regw) begin
            busy_next[waddr] = 1'b0;
        end
        if (issue_en && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign stall = ((chk_r1 != '0) && busy[chk_r1])
                || ((chk_r2 != '0) && busy[chk_r2])
                || (chk_rd_en && (chk_rd != '0) && busy[chk_rd]);

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: accepted writes are queued as expected commits
// and checked against regw/waddr/wdata one cycle later.
module tb_regfile_wb_ctrl;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    logic        clock;
    logic        nreset;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        regw;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  chk_r1;
    logic [4:0]  chk_r2;
    logic [4:0]  chk_rd;
    logic        chk_rd_en;
    logic        stall;

    int total = 0;
    int bad   = 0;
    wb_t sb[$];
    logic [4:0]  last_addr = '0;
    logic [31:0] last_data = '0;

    regfile_wb_ctrl #(.n(32)) dut (
        .clock     (clock),
        .nreset    (nreset),
        .issue_en  (issue_en),
        .issue_rd  (issue_rd),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .regw      (regw),
        .waddr     (waddr),
        .wdata     (wdata),
        .chk_r1    (chk_r1),
        .chk_r2    (chk_r2),
        .chk_rd    (chk_rd),
        .chk_rd_en (chk_rd_en),
        .stall     (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: check handshake/stall, queue the expected commit, then check the output stage.
    task automatic cycle(input logic e_ld, input logic e_alu, input logic e_stall);
        wb_t w;
        #1;
        chk("ld_ready", 32'(ld_ready), 32'(e_ld));
        chk("alu_ready", 32'(alu_ready), 32'(e_alu));
        chk("stall", 32'(stall), 32'(e_stall));
        if (e_ld) begin
            w.we = (ld_addr != 5'd0); w.addr = ld_addr; w.data = ld_data;
            sb.push_back(w);
        end else if (e_alu) begin
            w.we = (alu_addr != 5'd0); w.addr = alu_addr; w.data = alu_data;
            sb.push_back(w);
        end
        @(posedge clock);
        #1;
        if (sb.size() > 0) begin
            w = sb.pop_front();
            chk("regw", 32'(regw), 32'(w.we));
            chk("waddr", 32'(waddr), 32'(w.addr));
            chk("wdata", wdata, w.data);
            last_addr = w.addr;
            last_data = w.data;
        end else begin
            chk("regw_idle", 32'(regw), 32'd0);
            chk("waddr_hold", 32'(waddr), 32'(last_addr));
            chk("wdata_hold", wdata, last_data);
        end
    endtask

    initial begin
        nreset = 1'b0;
        issue_en = 1'b0; issue_rd = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        chk_r1 = '0; chk_r2 = '0; chk_rd = '0; chk_rd_en = 1'b0;

        #2;
        chk("rst_regw", 32'(regw), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk_r1 = 5'd5; chk_rd = 5'd6; chk_rd_en = 1'b1;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk_r1 = '0; chk_rd = '0; chk_rd_en = 1'b0;
        #9 nreset = 1'b1;
        @(posedge clock);
        #1;

        // Single ALU write.
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEAD_BEEF;
        cycle(1'b0, 1'b1, 1'b0);
        alu_valid = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);

        // Contention alternates starting with the load unit.
        ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 32'h0000_0A03;
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h0000_0B04;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        ld_valid = 1'b0; alu_valid = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);

        // Write to x0 is accepted but never enables the register file.
        ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'h0000_1234;
        cycle(1'b1, 1'b0, 1'b0);
        ld_valid = 1'b0; chk_r1 = 5'd3; chk_r2 = 5'd4;
        cycle(1'b0, 1'b0, 1'b0);
        chk_r1 = '0; chk_r2 = '0;

        // RAW hazard on x7 held across the issue->commit window.
        issue_en = 1'b1; issue_rd = 5'd7;
        cycle(1'b0, 1'b0, 1'b0);
        issue_en = 1'b0; chk_r1 = 5'd7; chk_r2 = 5'd0;
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'hCAFE_0007;
        cycle(1'b0, 1'b1, 1'b1);
        alu_valid = 1'b0;
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        chk_r1 = '0;

        // Same-cycle set and clear of x9: set wins.
        issue_en = 1'b1; issue_rd = 5'd9;
        cycle(1'b0, 1'b0, 1'b0);
        issue_en = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h9999_0009;
        cycle(1'b0, 1'b1, 1'b0);
        alu_valid = 1'b0;
        issue_en = 1'b1; issue_rd = 5'd9;
        cycle(1'b0, 1'b0, 1'b0);
        issue_en = 1'b0; chk_rd = 5'd9; chk_rd_en = 1'b1;
        cycle(1'b0, 1'b0, 1'b1);
        chk_rd_en = 1'b0;
        #1;
        chk("waw_disabled", 32'(stall), 32'd0);
        chk_rd = '0;

        // Reset with a write to x12 in flight drops it and clears the scoreboard.
        issue_en = 1'b1; issue_rd = 5'd12;
        ld_valid = 1'b1; ld_addr = 5'd12; ld_data = 32'h1212_1212;
        cycle(1'b1, 1'b0, 1'b0);
        issue_en = 1'b0; ld_valid = 1'b0; chk_r1 = 5'd12;
        #1;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        nreset = 1'b0;
        #1;
        chk("mid_rst_regw", 32'(regw), 32'd0);
        chk("mid_rst_waddr", 32'(waddr), 32'd0);
        chk("mid_rst_wdata", wdata, 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        #1 nreset = 1'b1;
        @(posedge clock);
        #1;
        chk("post_rst_stall", 32'(stall), 32'd0);
        chk("post_rst_regw", 32'(regw), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Write-back controller for the 32-entry integer register file (one write port, combinational reads, x0 hard-wired to zero).
- Arbitrates the single write port between the load unit and the ALU write-back using valid/ready handshakes, round-robin on contention.
- Registers the winning write into regw/waddr/wdata.
- Keeps a pending-write scoreboard so decode can stall on RAW/WAW hazards.

Parameters:
- n, 32, data width; matches the register file width.

Ports:
- clock  in  1  system clock, rising edge
- nreset  in  1  asynchronous active-low reset
- issue_en  in  1  decode issues an instruction that will write issue_rd
- issue_rd  in  5  destination register of issued instruction
- ld_valid  in  1  load unit has write-back data
- ld_ready  out  1  load write accepted this cycle
- ld_addr  in  5  load destination register
- ld_data  in  n  load write data
- alu_valid  in  1  ALU has write-back data
- alu_ready  out  1  ALU write accepted this cycle
- alu_addr  in  5  ALU destination register
- alu_data  in  n  ALU write data
- regw  out  1  register file write enable
- waddr  out  5  register file write address
- wdata  out  n  register file write data
- chk_r1, chk_r2  in  5  decode source registers to check
- chk_rd  in  5  decode destination register to check (WAW)
- chk_rd_en  in  1  chk_rd is meaningful
- stall  out  1  hazard: decode must hold

Behaviour:
- Reset (async, nreset=0):
  - regw=0, waddr=0, wdata=0, busy[31:0]=0, last_grant=ALU (so load wins first contention).
  - An in-flight write is dropped.
  - ld_ready/alu_ready follow combinationally; they are 0 while no valid is present.
- Arbitration (combinational):
  - Only one valid: that requester is granted.
  - Both valid: the requester not named by last_grant is granted.
  - last_grant updates only on cycles where both were valid.
  - ready = grant. The output stage drains every cycle, so there is no backpressure beyond losing arbitration.
  - transfer = valid && ready.
  - A requester holds valid, addr and data stable until ready. Loser ready=0; it retries next cycle.
- Output stage (registered, 1-cycle latency accept->regw):
  - On transfer: waddr<=addr, wdata<=data, regw<=(addr!=0).
  - No transfer: regw<=0; waddr and wdata hold.
  - A write to x0 is accepted (ready=1) but never asserts regw.
- Scoreboard busy[31:0]:
  - Set: issue_en && issue_rd!=0 sets busy[issue_rd] at the clock edge.
  - Clear: regw=1 clears busy[waddr] at the same edge the register file writes. Data is readable and busy is low from the next cycle.
  - Set and clear of the same index in one cycle: set wins.
  - busy[0] is never set.
- stall (combinational) = (chk_r1!=0 && busy[chk_r1]) || (chk_r2!=0 && busy[chk_r2]) || (chk_rd_en && chk_rd!=0 && busy[chk_rd]).
  - The WAW term guarantees at most one outstanding write per register; decode must not issue while stall=1.
- Write-backs to a register that is not busy are legal (e.g. after flush) and still write.
- No forwarding; stall covers the full issue->commit window.

Decomposition:
- Package regfile_pkg:
  - REG_AW=5, NREGS=32
  - typedef reg_addr_t (logic [4:0])
  - typedef enum grant_t {GNT_LD, GNT_ALU}
- Sub-module rr_arb2: two-requester round-robin arbiter holding last_grant.
  - Ports: clock, nreset, req[1:0], gnt[1:0].
- Scoreboard and output stage stay in regfile_wb_ctrl.

Test Plan:
- Reset then single ALU write: alu_valid=1, addr=5, data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle regw=1, waddr=5, wdata=0xDEADBEEF; following cycle regw=0.
- Contention: ld and alu valid for 4 cycles, addrs 3/4 -> grants LD, ALU, LD, ALU. Losing ready=0 each cycle; regw waddr sequence 3, 4, 3, 4.
- x0 drop: ld_valid, addr=0, data=0x1234 -> ld_ready=1; regw stays 0; busy unchanged.
- RAW hazard: issue_en, rd=7; then chk_r1=7 -> stall=1 until the cycle after regw=1 with waddr=7, then stall=0. chk_r2=0 never stalls.
- Set/clear collision: regw committing waddr=9 while issue_en rd=9 -> busy[9] remains 1; chk_rd_en, chk_rd=9 -> stall=1.
- Reset mid-operation: accept write to rd=12 (busy[12]=1), deassert nreset before the commit edge -> regw=0 and busy=0 immediately; after release, chk_r1=12 gives stall=0.
